// File: rtl/add_operand_loader_if.sv
// Operand stream and result handshake bundle for add_operand_loader.
// master = byte source / result sink, slave = the loader itself.
interface add_operand_loader_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             cin_in;
    logic [WIDTH:0]   res;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output din, din_valid, cin_in, res_ready,
        input  din_ready, res, res_valid
    );

    modport slave (
        input  din, din_valid, cin_in, res_ready,
        output din_ready, res, res_valid
    );
endinterface

// File: rtl/add_operand_loader.sv
// Loads two operand bytes into an external adder, pulses E for one cycle and captures {C8,S}.
// Optional macro ADD_LOADER_CHAIN_EN adds chain_first and a carry register for multi-byte adds.
module add_operand_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    add_operand_loader_if.slave bus,
`ifdef ADD_LOADER_CHAIN_EN
    input  logic             chain_first,
`endif
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             C0,
    output logic             E,
    input  logic [WIDTH-1:0] S,
    input  logic             C8
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GET_B = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c0;
    logic             r_e;
    logic [WIDTH:0]   r_res;
    logic             r_res_valid;
    logic             r_din_ready;
    logic             w_take;
    logic             w_c0_next;

    assign w_take = bus.din_valid & r_din_ready;

`ifdef ADD_LOADER_CHAIN_EN
    logic r_chain_carry;
    logic r_chain_first;

    // Chain state: remember whether this add starts a chain, and keep the last carry-out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain_carry <= 1'b0;
            r_chain_first <= 1'b0;
        end else begin
            if (r_state == IDLE && w_take) begin
                r_chain_first <= chain_first;
            end else begin
                r_chain_first <= r_chain_first;
            end
            if (r_state == EXEC) begin
                r_chain_carry <= C8;
            end else begin
                r_chain_carry <= r_chain_carry;
            end
        end
    end

    // Carry-in source: external cin for the first byte of a chain, stored carry otherwise
    always_comb begin
        w_c0_next = bus.cin_in;
        if (r_chain_first) begin
            w_c0_next = bus.cin_in;
        end else begin
            w_c0_next = r_chain_carry;
        end
    end
`else
    assign w_c0_next = bus.cin_in;
`endif

    // Operand loader FSM; din_ready is registered, so it reads 0 in reset and rises on the first edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_c0        <= 1'b0;
            r_e         <= 1'b0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_din_ready <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_din_ready <= 1'b1;
                    if (w_take) begin
                        r_a     <= bus.din;
                        r_state <= GET_B;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GET_B: begin
                    if (w_take) begin
                        r_b         <= bus.din;
                        r_c0        <= w_c0_next;
                        r_e         <= 1'b1;
                        r_din_ready <= 1'b0;
                        r_state     <= EXEC;
                    end else begin
                        r_state <= GET_B;
                    end
                end
                EXEC: begin
                    // Adder outputs are only trusted here, while E is high
                    r_res       <= {C8, S};
                    r_e         <= 1'b0;
                    r_res_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_din_ready <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_e         <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_din_ready <= 1'b0;
                end
            endcase
        end
    end

    assign A             = r_a;
    assign B             = r_b;
    assign C0            = r_c0;
    assign E             = r_e;
    assign bus.res       = r_res;
    assign bus.res_valid = r_res_valid;
    assign bus.din_ready = r_din_ready;

endmodule

// File: doc/add_operand_loader.md
ADD_OPERAND_LOADER -- requirements
Module: add_operand_loader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/sum width; it SHALL match the 8-bit adder it drives.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port din, input, WIDTH, the operand byte stream (first byte A, second byte B).
REQ-005 The block SHALL have port din_valid, input, 1, meaning din holds a valid byte.
REQ-006 The block SHALL have port din_ready, output, 1, meaning the block accepts din this cycle; a transfer occurs when din_valid and din_ready are both 1.
REQ-007 The block SHALL have port cin_in, input, 1, the carry-in sampled with the B byte.
REQ-008 The block SHALL have ports A, B (output, WIDTH), C0 (output, 1) and E (output, 1), which drive the adder inputs.
REQ-009 The block SHALL have ports S (input, WIDTH) and C8 (input, 1), which carry the adder sum and carry-out.
REQ-010 The block SHALL have port res, output, WIDTH+1, the captured result {C8,S}.
REQ-011 The block SHALL have port res_valid, output, 1, meaning res holds an unconsumed result.
REQ-012 The block SHALL have port res_ready, input, 1; res is consumed when res_valid and res_ready are both 1.

Function
REQ-013 The FSM SHALL have states IDLE, GET_B, EXEC and DONE, encoded in registers.
- IDLE: din_ready=1; on transfer, A<=din and go to GET_B.
- GET_B: din_ready=1; on transfer, B<=din, C0<=cin_in, and go to EXEC.
- EXEC: din_ready=0 and E=1 for exactly one cycle; res<={C8,S} at the end of the cycle; go to DONE.
- DONE: din_ready=0 and res_valid=1; on res_ready, go to IDLE with res_valid=0 on the next cycle.
REQ-014 E SHALL be 1 only in EXEC; in all other states E=0 while A, B and C0 hold their last loaded values.
REQ-015 Latency SHALL be two cycles: the B-accept edge leads to EXEC, and the next edge leads to res_valid=1.
REQ-016 S and C8 SHALL be treated as combinational from A, B, C0 and E, and SHALL be sampled only at the EXEC edge.
REQ-017 res, A, B and C0 SHALL stay stable while res_valid=1 and res_ready=0, for any number of cycles.
REQ-018 din_valid with din_ready=0 SHALL be ignored and no byte dropped; the source holds the byte until it is accepted.
REQ-019 A byte SHALL NOT be accepted in the same cycle that DONE is exited; the earliest next A accept is the first cycle in IDLE.
REQ-020 Arithmetic wrap SHALL be left to the adder: res[WIDTH]=C8 and res[WIDTH-1:0]=S, with no saturation.
REQ-021 din_valid toggling in GET_B without a transfer SHALL leave A unchanged.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, A=0, B=0, C0=0, E=0, res=0, res_valid=0 and chain carry=0.
REQ-023 Reset asserted in any state, including mid-EXEC, SHALL discard the operation; no res_valid pulse follows.
REQ-024 After rst_n rises, din_ready SHALL be 1 from the first clock edge.

Configuration
REQ-025 With macro ADD_LOADER_CHAIN_EN defined, the block SHALL add input chain_first (1 bit) and a chain-carry register loaded with C8 at each EXEC edge.
- When chain_first=1 at A accept, C0 SHALL take cin_in at B accept.
- When chain_first=0 at A accept, C0 SHALL take the chain-carry register at B accept.
REQ-026 With ADD_LOADER_CHAIN_EN undefined, the port chain_first and the chain register SHALL be absent, and C0 SHALL always take cin_in.

Verification
REQ-027 The bench SHALL check: din 50, then 70 with cin_in=0 and res_ready=1 -> E high for one cycle, then res=9'h078, res_valid for 1 cycle.
REQ-028 The bench SHALL check: 255, then 1 with cin 0 -> res=9'h100; then 200, 55 with cin 1 -> res=9'h100.
REQ-029 The bench SHALL check backpressure: 128+128 with res_ready=0 for 5 cycles -> res=9'h100 held and din_ready=0 throughout, then IDLE one cycle after res_ready=1.
REQ-030 The bench SHALL check reset: rst_n pulsed low during EXEC of 127+1 -> all outputs 0 at once, no res_valid, and the next 10+20 gives 9'h01E.
REQ-031 With CHAIN_EN, the bench SHALL check: 255+1 (chain_first=1, cin 0), then 0+0 (chain_first=0) -> res 9'h100, then 9'h001.
REQ-032 The bench SHALL check: din_valid held high through EXEC and DONE -> no extra accept, and the third byte is taken as the next A only in IDLE.
